// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: pattern mode codes,
// default 640x480@60 timing and the counter-width helper.
package vga_pkg;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CHECK = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_COLOR_W  = 3;

    // Width of a counter running 0..n-1; never less than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pin-side bundle of the VGA timing generator: pattern select in,
// sync/colour/coordinate/strobe outputs.
interface vga_timing_gen_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 3
);
    logic [1:0]         mode;
    logic               Hsynq;
    logic               Vsynq;
    logic [COLOR_W-1:0] Red;
    logic [COLOR_W-1:0] Green;
    logic [COLOR_W-1:0] Blue;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               active;
    logic               pix_en;
    logic               frame_start;

    modport master (
        input  mode,
        output Hsynq, Vsynq, Red, Green, Blue, x, y, active, pix_en, frame_start
    );

    modport slave (
        output mode,
        input  Hsynq, Vsynq, Red, Green, Blue, x, y, active, pix_en, frame_start
    );
endinterface

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable: divides clk by CLK_DIV. tick flags the edge that
// presents a new pixel; pix_en is its registered copy, high for that pixel's clk.
module vga_pix_tick
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic pix_en
);
    localparam int DW = count_width(CLK_DIV);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_n;

    always_comb begin
        div_n = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        tick  = (div_n == DW'(CLK_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            pix_en <= 1'b0;
        end else begin
            div_q  <= div_n;
            pix_en <= tick;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator. All outputs are
// registered on the pixel tick and describe the pixel held in x/y.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int COLOR_W  = DEF_COLOR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = count_width(H_TOTAL);
    localparam int Y_W     = count_width(V_TOTAL);

    logic               tick;
    logic               pix_en;
    logic [X_W-1:0]     x_q, x_n;
    logic [Y_W-1:0]     y_q, y_n;
    logic [1:0]         mode_q, mode_use;
    logic               origin, act_n, hs_n, vs_n;
    logic [COLOR_W-1:0] r_n, g_n, b_n;
    logic [2:0]         bar;
    logic [31:0]        xe, ye;

    vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .pix_en (pix_en)
    );

    always_comb begin
        x_n = x_q + 1'b1;
        y_n = y_q;
        if (x_q == X_W'(H_TOTAL - 1)) begin
            x_n = '0;
            y_n = (y_q == Y_W'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
        end
    end

    // Pattern is decoded from the coordinates about to be presented, so
    // colour, sync and x/y land together. The frame's mode is the live input
    // at (0,0) and the latched copy everywhere else.
    always_comb begin
        xe       = 32'(x_n);
        ye       = 32'(y_n);
        origin   = (x_n == '0) && (y_n == '0);
        mode_use = origin ? vga.mode : mode_q;
        act_n    = (xe < H_ACTIVE) && (ye < V_ACTIVE);
        hs_n     = (xe >= H_ACTIVE + H_FP && xe < H_ACTIVE + H_FP + H_SYNC) ? H_POL : ~H_POL;
        vs_n     = (ye >= V_ACTIVE + V_FP && ye < V_ACTIVE + V_FP + V_SYNC) ? V_POL : ~V_POL;
        bar      = 3'((xe * 8) / H_ACTIVE);
        r_n      = '0;
        g_n      = '0;
        b_n      = '0;
        if (act_n) begin
            case (mode_use)
                MODE_BARS: begin
                    r_n = {COLOR_W{bar[2]}};
                    g_n = {COLOR_W{bar[1]}};
                    b_n = {COLOR_W{bar[0]}};
                end
                MODE_CHECK: begin
                    r_n = {COLOR_W{xe[5] ^ ye[5]}};
                    g_n = {COLOR_W{xe[5] ^ ye[5]}};
                    b_n = {COLOR_W{xe[5] ^ ye[5]}};
                end
                MODE_GRAD: begin
                    r_n = COLOR_W'((xe << COLOR_W) / H_ACTIVE);
                    g_n = COLOR_W'((ye << COLOR_W) / V_ACTIVE);
                end
                MODE_SOLID: begin
                    r_n = '1;
                    g_n = '1;
                    b_n = '1;
                end
                default: begin
                    r_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q             <= X_W'(H_TOTAL - 1);
            y_q             <= Y_W'(V_TOTAL - 1);
            mode_q          <= MODE_BARS;
            vga.Hsynq       <= ~H_POL;
            vga.Vsynq       <= ~V_POL;
            vga.Red         <= '0;
            vga.Green       <= '0;
            vga.Blue        <= '0;
            vga.active      <= 1'b0;
            vga.frame_start <= 1'b0;
        end else if (tick) begin
            x_q             <= x_n;
            y_q             <= y_n;
            if (origin) mode_q <= vga.mode;
            vga.Hsynq       <= hs_n;
            vga.Vsynq       <= vs_n;
            vga.Red         <= r_n;
            vga.Green       <= g_n;
            vga.Blue        <= b_n;
            vga.active      <= act_n;
            vga.frame_start <= origin;
        end else begin
            vga.frame_start <= 1'b0;
        end
    end

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.pix_en = pix_en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-size instances (divided clock with
// low-active syncs, undivided with high-active syncs) against a pixel-list model.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int A_HA = 80, A_HF = 4, A_HS = 8, A_HB = 4;
    localparam int A_VA = 40, A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_DIV = 2, A_CW = 3;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_DIV = 1, B_CW = 2;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, dv, cw;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int x, y, r, g, b;
        bit hs, vs, act, fs, pe;
    } pix_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   done_a = 1'b0;
    bit   done_b = 1'b0;
    int   last_fs_a = -1;
    int   last_fs_b = -1;
    pix_t qa[$];
    pix_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    vga_timing_gen_if #(.X_W(count_width(A_HT)), .Y_W(count_width(A_VT)), .COLOR_W(A_CW)) va ();
    vga_timing_gen_if #(.X_W(count_width(B_HT)), .Y_W(count_width(B_VT)), .COLOR_W(B_CW)) vb ();

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(A_DIV), .COLOR_W(A_CW)
    ) dut_a (.clk(clk), .rst_n(rst_a), .vga(va));

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(B_DIV), .COLOR_W(B_CW)
    ) dut_b (.clk(clk), .rst_n(rst_b), .vga(vb));

    function automatic cfg_t cfg_of(input int w);
        cfg_t c;
        if (w == 0) begin
            c.ha = A_HA; c.hf = A_HF; c.hs = A_HS; c.hb = A_HB;
            c.va = A_VA; c.vf = A_VF; c.vs = A_VS; c.vb = A_VB;
            c.dv = A_DIV; c.cw = A_CW; c.hp = 1'b0; c.vp = 1'b0;
        end else begin
            c.ha = B_HA; c.hf = B_HF; c.hs = B_HS; c.hb = B_HB;
            c.va = B_VA; c.vf = B_VF; c.vs = B_VS; c.vb = B_VB;
            c.dv = B_DIV; c.cw = B_CW; c.hp = 1'b1; c.vp = 1'b1;
        end
        return c;
    endfunction

    // Expected pixel straight from the written rules: sync windows, bar index,
    // checker bit 5, scaled gradient, solid.
    function automatic pix_t exp_pix(input cfg_t c, input int x, input int y, input int m);
        pix_t p;
        int mx = (1 << c.cw) - 1;
        int bi;
        p.x = x; p.y = y; p.pe = 1'b1;
        p.fs  = (x == 0 && y == 0);
        p.act = (x < c.ha && y < c.va);
        p.hs  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
        p.vs  = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : !c.vp;
        p.r = 0; p.g = 0; p.b = 0;
        if (p.act) begin
            case (m)
                0: begin
                    bi  = (x * 8) / c.ha;
                    p.r = ((bi >> 2) & 1) != 0 ? mx : 0;
                    p.g = ((bi >> 1) & 1) != 0 ? mx : 0;
                    p.b = (bi & 1) != 0 ? mx : 0;
                end
                1: if ((((x >> 5) ^ (y >> 5)) & 1) != 0) begin
                    p.r = mx; p.g = mx; p.b = mx;
                end
                2: begin
                    p.r = (x * (1 << c.cw)) / c.ha;
                    p.g = (y * (1 << c.cw)) / c.va;
                end
                default: begin
                    p.r = mx; p.g = mx; p.b = mx;
                end
            endcase
        end
        return p;
    endfunction

    function automatic pix_t reset_pix(input cfg_t c);
        pix_t p;
        p.x = c.ha + c.hf + c.hs + c.hb - 1;
        p.y = c.va + c.vf + c.vs + c.vb - 1;
        p.hs = !c.hp; p.vs = !c.vp;
        p.act = 1'b0; p.fs = 1'b0; p.pe = 1'b0;
        p.r = 0; p.g = 0; p.b = 0;
        return p;
    endfunction

    function automatic pix_t snap(input int w);
        pix_t p;
        if (w == 0) begin
            p.x = int'(va.x); p.y = int'(va.y);
            p.r = int'(va.Red); p.g = int'(va.Green); p.b = int'(va.Blue);
            p.hs = va.Hsynq; p.vs = va.Vsynq; p.act = va.active;
            p.fs = va.frame_start; p.pe = va.pix_en;
        end else begin
            p.x = int'(vb.x); p.y = int'(vb.y);
            p.r = int'(vb.Red); p.g = int'(vb.Green); p.b = int'(vb.Blue);
            p.hs = vb.Hsynq; p.vs = vb.Vsynq; p.act = vb.active;
            p.fs = vb.frame_start; p.pe = vb.pix_en;
        end
        return p;
    endfunction

    function automatic string fmt(input pix_t p);
        return $sformatf("x=%0d y=%0d hs=%0d vs=%0d act=%0d fs=%0d pe=%0d rgb=%0d/%0d/%0d",
                         p.x, p.y, p.hs, p.vs, p.act, p.fs, p.pe, p.r, p.g, p.b);
    endfunction

    function automatic bit same(input pix_t a, input pix_t e);
        return a.x == e.x && a.y == e.y && a.hs == e.hs && a.vs == e.vs && a.act == e.act &&
               a.fs == e.fs && a.pe == e.pe && a.r == e.r && a.g == e.g && a.b == e.b;
    endfunction

    task automatic check(input bit ok, input string name, input string got, input string want);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    task automatic check_reset(input int w, input string name);
        pix_t a = snap(w);
        pix_t e = reset_pix(cfg_of(w));
        check(same(a, e), name, fmt(a), fmt(e));
    endtask

    task automatic set_mode(input int w, input int m);
        if (w == 0) va.mode = 2'(m);
        else vb.mode = 2'(m);
    endtask

    task automatic set_rst(input int w, input bit r);
        if (w == 0) rst_a = r;
        else rst_b = r;
    endtask

    // Presents npix pixels of one frame starting at (0,0). fm is the frame's
    // mode; at pixel gl the mode input is changed to gm, which must not show
    // until the following frame. Negative arguments are randomised.
    task automatic run_frame(input int w, input int npix, input int fm, input int gm, input int gl);
        cfg_t c   = cfg_of(w);
        int   ht  = c.ha + c.hf + c.hs + c.hb;
        int   tot = ht * (c.va + c.vf + c.vs + c.vb);
        if (fm < 0) fm = int'($urandom_range(0, 3));
        if (gm < 0) gm = int'($urandom_range(0, 3));
        if (gl < 0) gl = int'($urandom_range(1, tot - 1));
        for (int p = 0; p < npix; p++) begin
            if (w == 0) qa.push_back(exp_pix(c, p % ht, p / ht, fm));
            else qb.push_back(exp_pix(c, p % ht, p / ht, fm));
        end
        for (int p = 0; p < npix; p++) begin
            if (p == 0) set_mode(w, fm);
            else if (p == gl) set_mode(w, gm);
            repeat ((p == npix - 1 && npix < tot) ? 1 : c.dv) @(negedge clk);
        end
    endtask

    task automatic drive(input int w, input int nframes, input int rx, input int ry);
        cfg_t c   = cfg_of(w);
        int   ht  = c.ha + c.hf + c.hs + c.hb;
        int   tot = ht * (c.va + c.vf + c.vs + c.vb);
        set_rst(w, 1'b0);
        set_mode(w, 0);
        repeat (5) @(negedge clk);
        check_reset(w, (w == 0) ? "a_reset" : "b_reset");
        set_rst(w, 1'b1);
        run_frame(w, tot, 0, 1, 20 * ht);
        run_frame(w, tot, 1, -1, -1);
        for (int f = 0; f < nframes; f++) run_frame(w, tot, -1, -1, -1);
        run_frame(w, ry * ht + rx + 1, -1, -1, -1);
        set_rst(w, 1'b0);
        @(negedge clk);
        check_reset(w, (w == 0) ? "a_midframe_reset" : "b_midframe_reset");
        set_rst(w, 1'b1);
        run_frame(w, tot, 3, 2, -1);
        run_frame(w, tot, 2, 0, -1);
        set_rst(w, 1'b0);
        @(negedge clk);
        check_reset(w, (w == 0) ? "a_final_reset" : "b_final_reset");
    endtask

    initial begin
        drive(0, 1, 50, 20);
        done_a = 1'b1;
    end

    initial begin
        drive(1, 12, 5, 2);
        done_b = 1'b1;
    end

    task automatic pop_check(input int w);
        pix_t a = snap(w);
        pix_t e;
        if (w == 0 && qa.size() == 0 || w == 1 && qb.size() == 0) begin
            check(1'b0, (w == 0) ? "a_extra_pixel" : "b_extra_pixel", fmt(a), "no pixel");
            return;
        end
        e = (w == 0) ? qa.pop_front() : qb.pop_front();
        check(same(a, e), (w == 0) ? "a_pixel" : "b_pixel", fmt(a), fmt(e));
    endtask

    always @(posedge clk) begin
        #1;
        if (va.pix_en === 1'b1) pop_check(0);
        if (vb.pix_en === 1'b1) pop_check(1);
        if (!rst_a) last_fs_a = -1;
        else if (va.frame_start === 1'b1) begin
            if (last_fs_a >= 0)
                check(cyc - last_fs_a == A_DIV * A_HT * A_VT, "a_frame_period",
                      $sformatf("%0d", cyc - last_fs_a), $sformatf("%0d", A_DIV * A_HT * A_VT));
            last_fs_a = cyc;
        end
        if (!rst_b) last_fs_b = -1;
        else if (vb.frame_start === 1'b1) begin
            if (last_fs_b >= 0)
                check(cyc - last_fs_b == B_DIV * B_HT * B_VT, "b_frame_period",
                      $sformatf("%0d", cyc - last_fs_b), $sformatf("%0d", B_DIV * B_HT * B_VT));
            last_fs_b = cyc;
        end
    end

    initial begin
        while (!(done_a && done_b) && cyc < 90000) @(posedge clk);
        check(done_a && done_b, "timeout", $sformatf("done=%0d/%0d", done_a, done_b), "done=1/1");
        repeat (3) @(posedge clk);
        #2;
        check(qa.size() == 0, "a_pixels_left", $sformatf("%0d", qa.size()), "0");
        check(qb.size() == 0, "b_pixels_left", $sformatf("%0d", qb.size()), "0");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
